// File: rtl/traffic_monitor.sv
// traffic_monitor
//   Watches the light codes of a four-way intersection and checks that the
//   controller steps through the eight phases in order, holding each phase
//   for the required dwell time. Faults are latched until cleared.
//
//   Parameter
//     DWELL        cycles each phase must be held (2..15)
//
//   Ports
//     clk          single clock, rising edge
//     rst          synchronous, active-high reset
//     N, S, W, E   light codes: 001 green, 010 yellow, 100 red
//     clr          fault-clear request (only acts in FAULT)
//     locked       high while tracking a valid sequence
//     fault        sticky fault flag
//     fault_code   cause of the first fault (0 when no fault)
//     phase        last legal decoded phase
//     cycle_cnt    completed signal cycles (7 -> 0 transitions), wraps
//
//   Build option
//     TRAFFIC_MONITOR_DWELL_CHECK_EN  adds the dwell counter and the
//                                     SHORT (5) / LONG (6) fault codes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SYNC  | waiting for a legal successor phase to lock onto
//   TRACK | locked; checking order (and dwell, when enabled)
//   FAULT | fault latched; waits for clr with a clean sample

module traffic_monitor #(
  parameter int DWELL = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] N,
  input  logic [2:0] S,
  input  logic [2:0] W,
  input  logic [2:0] E,
  input  logic       clr,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] phase,
  output logic [7:0] cycle_cnt
);

  if (DWELL < 2 || DWELL > 15) begin : g_dwell_range
    $error("traffic_monitor: DWELL must be in 2..15");
  end

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_DARK     = 3'd3;
  localparam logic [2:0] FC_SEQ      = 3'd4;
  localparam logic [2:0] FC_SHORT    = 3'd5;
  localparam logic [2:0] FC_LONG     = 3'd6;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       locked_q, locked_d;
  logic       fault_q, fault_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic [2:0] phase_q, phase_d;
  logic [7:0] cycle_cnt_q, cycle_cnt_d;

  // Direction index doubles as the upper two bits of the decoded phase.
  logic [2:0] dir_code [4];
  assign dir_code[0] = N;
  assign dir_code[1] = S;
  assign dir_code[2] = W;
  assign dir_code[3] = E;

  logic       any_illegal;
  logic [2:0] nonred_cnt;
  logic [2:0] dec_phase;
  logic [2:0] struct_code;
  logic       legal;
  logic       is_same;
  logic       is_succ;
  logic       dwell_short;
  logic       dwell_long;
  logic [2:0] err_code;

  always_comb begin
    any_illegal = 1'b0;
    nonred_cnt  = 3'd0;
    dec_phase   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!(dir_code[i] inside {GRN, YEL, RED})) any_illegal = 1'b1;
      if (dir_code[i] != RED) begin
        nonred_cnt = nonred_cnt + 3'd1;
        dec_phase  = {2'(i), dir_code[i] == YEL};
      end
    end
  end

  // Structural priority: illegal code, then all-dark, then conflict.
  always_comb begin
    if (any_illegal)              struct_code = FC_ILLEGAL;
    else if (nonred_cnt == 3'd0)  struct_code = FC_DARK;
    else if (nonred_cnt != 3'd1)  struct_code = FC_CONFLICT;
    else                          struct_code = FC_NONE;
  end

  assign legal   = (struct_code == FC_NONE);
  assign is_same = (dec_phase == phase_q);
  assign is_succ = (dec_phase == phase_q + 3'd1);

`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
  localparam logic [3:0] DWELL_C = 4'(DWELL);

  logic [3:0] dwell_q, dwell_d;

  assign dwell_short = (dwell_q < DWELL_C);
  assign dwell_long  = (dwell_q == DWELL_C);

  // Counts samples of the current phase; restarts at 1 on every successor
  // (also the one that locks from SYNC). Saturates at DWELL since the next
  // same-phase sample is a LONG fault.
  always_comb begin
    dwell_d = dwell_q;
    if (legal && state_q != FAULT) begin
      if (is_succ)
        dwell_d = 4'd1;
      else if (is_same && state_q == TRACK && !dwell_long)
        dwell_d = dwell_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dwell_q <= 4'd0;
    else     dwell_q <= dwell_d;
  end
`else
  assign dwell_short = 1'b0;
  assign dwell_long  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    phase_d      = phase_q;
    cycle_cnt_d  = cycle_cnt_q;
    err_code     = FC_NONE;
    unique case (state_q)
      SYNC: begin
        if (!legal) begin
          err_code = struct_code;
        end else begin
          phase_d = dec_phase;
          if (is_succ) state_d = TRACK;
        end
      end
      TRACK: begin
        if (!legal) begin
          err_code = struct_code;
        end else if (is_same) begin
          if (dwell_long) err_code = FC_LONG;
        end else if (!is_succ) begin
          err_code = FC_SEQ;
        end else if (dwell_short) begin
          err_code = FC_SHORT;
        end else begin
          phase_d = dec_phase;
          if (phase_q == 3'd7) cycle_cnt_d = cycle_cnt_q + 8'd1;
        end
      end
      FAULT: begin
        // A clear on a structurally bad sample re-faults with the new cause.
        if (clr) begin
          if (!legal) begin
            fault_code_d = struct_code;
          end else begin
            state_d      = SYNC;
            fault_d      = 1'b0;
            fault_code_d = FC_NONE;
            phase_d      = dec_phase;
          end
        end
      end
      default: state_d = SYNC;
    endcase
    if (err_code != FC_NONE) begin
      state_d      = FAULT;
      fault_d      = 1'b1;
      fault_code_d = err_code;
    end
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      phase_q      <= 3'd0;
      cycle_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      phase_q      <= phase_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign phase      = phase_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
module tb_traffic_monitor;
  localparam int DWELL = 8;
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
  localparam bit DWELL_CHK = 1'b1;
`else
  localparam bit DWELL_CHK = 1'b0;
`endif
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [11:0] DARK = {RED, RED, RED, RED};
  localparam logic [11:0] CONFL = {GRN, GRN, RED, RED};

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [2:0] N, S, W, E;
  logic       locked, fault;
  logic [2:0] fault_code, phase;
  logic [7:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = sync, 1 = track, 2 = fault.
  int m_mode = 0, m_phase = 0, m_run = 0, m_code = 0, m_cycles = 0;
  bit m_fault = 1'b0;

  traffic_monitor #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .N(N), .S(S), .W(W), .E(E), .clr(clr),
    .locked(locked), .fault(fault), .fault_code(fault_code),
    .phase(phase), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lights_for(input int p);
    logic [11:0] l;
    l = DARK;
    l[11-3*(p/2) -: 3] = (p % 2 == 1) ? YEL : GRN;
    return l;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {locked, fault, fault_code, phase, cycle_cnt};
  endfunction

  function automatic logic [15:0] model_vec();
    return {m_mode == 1, m_fault, 3'(m_code), 3'(m_phase), 8'(m_cycles)};
  endfunction

  task automatic model_raise(input int code);
    m_mode = 2; m_fault = 1'b1; m_code = code;
  endtask

  task automatic model_step(input logic [11:0] l, input logic c, input logic r);
    int nonred, p, code;
    bit bad;
    logic [2:0] lc;
    nonred = 0; p = 0; bad = 1'b0;
    for (int d = 0; d < 4; d++) begin
      lc = l[11-3*d -: 3];
      if (!(lc inside {GRN, YEL, RED})) bad = 1'b1;
      if (lc != RED) begin
        nonred++;
        p = 2*d + ((lc == YEL) ? 1 : 0);
      end
    end
    if (bad) code = 1;
    else if (nonred == 0) code = 3;
    else if (nonred > 1) code = 2;
    else code = 0;
    if (r) begin
      m_mode = 0; m_fault = 1'b0; m_code = 0; m_phase = 0; m_cycles = 0; m_run = 0;
    end else if (m_mode == 2) begin
      if (c) begin
        if (code != 0) m_code = code;
        else begin m_mode = 0; m_fault = 1'b0; m_code = 0; m_phase = p; end
      end
    end else if (code != 0) model_raise(code);
    else if (m_mode == 0) begin
      if (p == (m_phase + 1) % 8) begin m_mode = 1; m_run = 1; end
      m_phase = p;
    end else if (p == m_phase) begin
      m_run++;
      if (DWELL_CHK && m_run > DWELL) model_raise(6);
    end else if (p != (m_phase + 1) % 8) model_raise(4);
    else if (DWELL_CHK && m_run < DWELL) model_raise(5);
    else begin
      if (m_phase == 7) m_cycles = (m_cycles + 1) % 256;
      m_phase = p; m_run = 1;
    end
  endtask

  task automatic drive(input logic [11:0] l, input logic c, input logic r);
    {N, S, W, E} = l; clr = c; rst = r;
    model_step(l, c, r);
    @(posedge clk); #1;
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) drive(lights_for(p), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(12'($urandom), 1'($urandom), 1'b1);
      checks++;
      if (dut_vec() !== 16'h0) begin
        failures++; $display("FAIL reset: got %h want %h", dut_vec(), 16'h0);
      end
    end
  endtask

  task automatic test_nominal();
    int n = 0;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 8; p++)
        for (int k = 0; k < DWELL; k++) begin
          drive(lights_for(p), 1'b0, 1'b0);
          n++;
          checks++;
          if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL nominal[%0d]: got %h want %h", n, dut_vec(), model_vec());
          end
          checks++;
          if (locked !== (n > DWELL) || fault !== 1'b0) begin
            failures++; $display("FAIL nominal_lock[%0d]: locked=%b fault=%b want locked=%b fault=0",
                                 n, locked, fault, n > DWELL);
          end
        end
    drive(lights_for(0), 1'b0, 1'b0);
    checks++;
    if (cycle_cnt !== 8'd2 || locked !== 1'b1) begin
      failures++; $display("FAIL nominal_cycles: cycle_cnt=%0d locked=%b want 2 1", cycle_cnt, locked);
    end
  endtask

  task automatic test_conflict();
    drive(lights_for(0), 1'b0, 1'b1);
    hold(0, DWELL); hold(1, DWELL); hold(2, 3);
    checks++;
    if (locked !== 1'b1 || phase !== 3'd2) begin
      failures++; $display("FAIL conflict_pre: locked=%b phase=%0d want 1 2", locked, phase);
    end
    drive(CONFL, 1'b0, 1'b0);
    checks++;
    if ({locked, fault, fault_code, phase} !== {1'b0, 1'b1, 3'd2, 3'd2}) begin
      failures++; $display("FAIL conflict: l/f/code/ph=%b/%b/%0d/%0d want 0/1/2/2",
                           locked, fault, fault_code, phase);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL conflict_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_illegal_dark();
    logic [11:0] sl [9];
    logic        sc [9];
    logic [7:0]  se [9];
    sl = '{DARK, {3'b111, RED, RED, RED}, lights_for(2), {RED, RED, 3'b011, RED},
           lights_for(2), DARK, lights_for(2), lights_for(2), lights_for(3)};
    sc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    se = '{8'b0_1_010_010, 8'b0_1_001_010, 8'b0_0_000_010, 8'b0_1_001_010,
           8'b0_0_000_010, 8'b0_1_011_010, 8'b0_0_000_010, 8'b0_0_000_010,
           8'b1_0_000_011};
    for (int i = 0; i < 9; i++) begin
      drive(sl[i], sc[i], 1'b0);
      checks++;
      if ({locked, fault, fault_code, phase} !== se[i]) begin
        failures++; $display("FAIL illegal_dark[%0d]: got %b want %b", i,
                             {locked, fault, fault_code, phase}, se[i]);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL illegal_dark_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_sequence();
    logic [11:0] sl [5];
    sl = '{lights_for(2), CONFL, DARK, {3'b000, RED, RED, RED}, lights_for(1)};
    drive(lights_for(0), 1'b0, 1'b1);
    hold(7, 1); hold(0, DWELL);
    checks++;
    if (locked !== 1'b1 || phase !== 3'd0) begin
      failures++; $display("FAIL seq_pre: locked=%b phase=%0d want 1 0", locked, phase);
    end
    for (int i = 0; i < 5; i++) begin
      drive(sl[i], 1'b0, 1'b0);
      checks++;
      if ({locked, fault, fault_code, phase} !== {1'b0, 1'b1, 3'd4, 3'd0}) begin
        failures++; $display("FAIL seq[%0d]: l/f/code/ph=%b/%b/%0d/%0d want 0/1/4/0",
                             i, locked, fault, fault_code, phase);
      end
    end
  endtask

  task automatic test_dwell();
    logic [4:0] want;
    drive(lights_for(0), 1'b0, 1'b1);
    hold(0, DWELL); hold(1, 5);
    drive(lights_for(2), 1'b0, 1'b0);
    want = DWELL_CHK ? {1'b0, 1'b1, 3'd5} : {1'b1, 1'b0, 3'd0};
    checks++;
    if ({locked, fault, fault_code} !== want) begin
      failures++; $display("FAIL dwell_short: got %b want %b", {locked, fault, fault_code}, want);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL dwell_short_model: got %h want %h", dut_vec(), model_vec());
    end
    drive(lights_for(0), 1'b0, 1'b1);
    hold(0, DWELL); hold(1, DWELL); hold(2, DWELL);
    checks++;
    if ({locked, fault, fault_code} !== 5'b1_0_000) begin
      failures++; $display("FAIL dwell_exact: got %b want 10000", {locked, fault, fault_code});
    end
    drive(lights_for(2), 1'b0, 1'b0);
    want = DWELL_CHK ? {1'b0, 1'b1, 3'd6} : {1'b1, 1'b0, 3'd0};
    checks++;
    if ({locked, fault, fault_code} !== want) begin
      failures++; $display("FAIL dwell_long: got %b want %b", {locked, fault, fault_code}, want);
    end
  endtask

  task automatic test_recovery();
    drive(CONFL, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1 || locked !== 1'b0) begin
      failures++; $display("FAIL recov_fault: fault=%b locked=%b want 1 0", fault, locked);
    end
    drive(lights_for(2), 1'b1, 1'b0);
    checks++;
    if ({locked, fault, fault_code, phase} !== {1'b0, 1'b0, 3'd0, 3'd2}) begin
      failures++; $display("FAIL recov_clr: got %b want 0000010", {locked, fault, fault_code, phase});
    end
    drive(lights_for(3), 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || phase !== 3'd3) begin
      failures++; $display("FAIL recov_lock: locked=%b phase=%0d want 1 3", locked, phase);
    end
    hold(3, DWELL - 1);
    for (int p = 4; p < 8; p++) hold(p, DWELL);
    drive(lights_for(0), 1'b0, 1'b0);
    checks++;
    if (cycle_cnt !== 8'd1 || locked !== 1'b1) begin
      failures++; $display("FAIL recov_cycle: cycle_cnt=%0d locked=%b want 1 1", cycle_cnt, locked);
    end
    drive(12'($urandom), 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 16'h0) begin
      failures++; $display("FAIL rst_track: got %h want 0000", dut_vec());
    end
    drive(CONFL, 1'b0, 1'b0);
    drive(DARK, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 16'h0) begin
      failures++; $display("FAIL rst_fault: got %h want 0000", dut_vec());
    end
  endtask

  task automatic test_cnt_wrap();
    drive(lights_for(0), 1'b0, 1'b1);
    hold(0, DWELL);
    for (int k = 0; k < 256; k++) begin
      for (int p = 1; p < 8; p++) hold(p, DWELL);
      hold(0, DWELL);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL wrap_model[%0d]: got %h want %h", k, dut_vec(), model_vec());
      end
      if (k >= 254) begin
        checks++;
        if (cycle_cnt !== 8'((k + 1) % 256)) begin
          failures++; $display("FAIL wrap[%0d]: cycle_cnt=%0d want %0d", k, cycle_cnt, (k + 1) % 256);
        end
      end
    end
  endtask

  task automatic test_random();
    int cp = 0, r = 0, tgt = DWELL, x;
    logic [11:0] l;
    logic c, rr;
    for (int i = 0; i < 3000; i++) begin
      x = $urandom_range(0, 99);
      c = ($urandom_range(0, 15) == 0);
      rr = 1'b0;
      if (x < 2) begin
        rr = 1'b1; l = 12'($urandom); cp = 0; r = 0;
      end else if (x < 6) begin
        l = 12'($urandom);
      end else if (x < 9) begin
        cp = $urandom_range(0, 7); r = 1; l = lights_for(cp);
      end else if (x < 13) begin
        l = lights_for(cp); c = 1'b1;
      end else begin
        if (r >= tgt) begin
          cp = (cp + 1) % 8; r = 0;
          tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(DWELL - 1, DWELL + 1) : DWELL;
        end
        r++;
        l = lights_for(cp);
      end
      drive(l, c, rr);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random[%0d]: in=%h clr=%b rst=%b got %h want %h",
                             i, l, c, rr, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_conflict();
    test_illegal_dark();
    test_sequence();
    test_dwell();
    test_recovery();
    test_cnt_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
